// File: rtl/divider_bank.sv
// Bank of CH programmable clock dividers/timers with periodic or one-shot mode.
// Optional DIVIDER_IRQ_EN adds per-channel sticky pending bits and an irq line.
module divider_bank #(
    parameter  int CH = 4,
    parameter  int W  = 8,
    localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic [CH-1:0]   en,
    input  logic            wr,
    input  logic [CW-1:0]   wr_ch,
    input  logic [W-1:0]    wr_top,
    input  logic [W-1:0]    wr_duty,
    input  logic            wr_oneshot,
    output logic [CH-1:0]   tick,
    output logic [CH-1:0]   out,
    output logic [CH-1:0]   running,
    output logic [CH*W-1:0] count
`ifdef DIVIDER_IRQ_EN
    ,
    input  logic [CH-1:0]   irq_ack,
    output logic [CH-1:0]   irq_pending,
    output logic            irq
`endif
);

    logic [CH-1:0] w_sel;
    logic [CH-1:0] w_wrap;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [W-1:0] r_top;
        logic [W-1:0] r_duty;
        logic [W-1:0] r_count;
        logic         r_oneshot;
        logic         r_running;
        logic         r_tick;
        logic         r_out;

        // Out-of-range channel numbers never match any channel index.
        assign w_sel[c]  = wr && (int'(wr_ch) == c);
        assign w_wrap[c] = !w_sel[c] && r_running && en[c]
                           && (r_count == r_top);

        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                r_top     <= '0;
                r_duty    <= '0;
                r_count   <= '0;
                r_oneshot <= 1'b0;
                r_running <= 1'b0;
                r_tick    <= 1'b0;
                r_out     <= 1'b0;
            end else if (w_sel[c]) begin
                r_top     <= wr_top;
                r_duty    <= wr_duty;
                r_oneshot <= wr_oneshot;
                r_count   <= '0;
                r_out     <= 1'b0;
                r_tick    <= 1'b0;
                r_running <= 1'b1;
            end else if (r_running && en[c]) begin
                if (r_count == r_top) begin
                    r_count <= '0;
                    r_tick  <= 1'b1;
                    r_out   <= 1'b0;
                    if (r_oneshot) begin
                        r_running <= 1'b0;
                    end
                end else begin
                    r_count <= r_count + 1'b1;
                    r_tick  <= 1'b0;
                    if (r_count == r_duty) begin
                        r_out <= 1'b1;
                    end
                end
            end else begin
                r_tick <= 1'b0;
            end
        end

        assign tick[c]            = r_tick;
        assign out[c]             = r_out;
        assign running[c]         = r_running;
        assign count[c*W +: W]    = r_count;
    end

`ifdef DIVIDER_IRQ_EN
    logic [CH-1:0] r_pend;

    // A new tick outranks a same-cycle acknowledge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_wrap | (r_pend & ~irq_ack);
        end
    end

    assign irq_pending = r_pend;
    assign irq         = |r_pend;
`else
    logic w_unused;
    assign w_unused = |w_wrap;
`endif

endmodule

// File: tb/tb_divider_bank.sv
// Directed self-checking bench for divider_bank (CH=5 so wr_ch can go out of range).
// Build with DIVIDER_IRQ_EN defined to exercise the interrupt extension.
module tb_divider_bank;
    localparam int CH = 5;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            n_reset;
    logic [CH-1:0]   en;
    logic            wr;
    logic [2:0]      wr_ch;
    logic [W-1:0]    wr_top;
    logic [W-1:0]    wr_duty;
    logic            wr_oneshot;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   out;
    logic [CH-1:0]   running;
    logic [CH*W-1:0] count;
`ifdef DIVIDER_IRQ_EN
    logic [CH-1:0]   irq_ack;
    logic [CH-1:0]   irq_pending;
    logic            irq;
`endif

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] cnt;
        logic       tk;
        logic       o;
    } vec_t;
    vec_t tbl [12];

    divider_bank #(.CH(CH), .W(W)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .en         (en),
        .wr         (wr),
        .wr_ch      (wr_ch),
        .wr_top     (wr_top),
        .wr_duty    (wr_duty),
        .wr_oneshot (wr_oneshot),
        .tick       (tick),
        .out        (out),
        .running    (running),
        .count      (count)
`ifdef DIVIDER_IRQ_EN
        ,
        .irq_ack    (irq_ack),
        .irq_pending(irq_pending),
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] cnt(input int c);
        return count[c*W +: W];
    endfunction

    task automatic wr_cfg(input int ch, input int top, input int duty,
                          input bit os);
        wr         = 1'b1;
        wr_ch      = 3'(ch);
        wr_top     = 8'(top);
        wr_duty    = 8'(duty);
        wr_oneshot = os;
        step();
        wr         = 1'b0;
    endtask

    initial begin
        int bad;
        int nt;

        // ch0 top=5 duty=2: count, tick, out after edges 1..12
        tbl[0]  = '{8'd1, 1'b0, 1'b0};
        tbl[1]  = '{8'd2, 1'b0, 1'b0};
        tbl[2]  = '{8'd3, 1'b0, 1'b1};
        tbl[3]  = '{8'd4, 1'b0, 1'b1};
        tbl[4]  = '{8'd5, 1'b0, 1'b1};
        tbl[5]  = '{8'd0, 1'b1, 1'b0};
        tbl[6]  = '{8'd1, 1'b0, 1'b0};
        tbl[7]  = '{8'd2, 1'b0, 1'b0};
        tbl[8]  = '{8'd3, 1'b0, 1'b1};
        tbl[9]  = '{8'd4, 1'b0, 1'b1};
        tbl[10] = '{8'd5, 1'b0, 1'b1};
        tbl[11] = '{8'd0, 1'b1, 1'b0};

        n_reset    = 1'b0;
        en         = '0;
        wr         = 1'b0;
        wr_ch      = '0;
        wr_top     = '0;
        wr_duty    = '0;
        wr_oneshot = 1'b0;
`ifdef DIVIDER_IRQ_EN
        irq_ack    = '0;
`endif
        step();
        step();
        chk("rst_tick", tick, 0);
        chk("rst_out", out, 0);
        chk("rst_running", running, 0);
        chk("rst_count", count, 0);
        n_reset = 1'b1;
        en      = '1;

        // periodic ch0, table driven
        wr_cfg(0, 5, 2, 1'b0);
        chk("w0_running", running, 5'b00001);
        chk("w0_count", cnt(0), 0);
        chk("w0_tick", tick[0], 0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("t%0d_cnt", i + 1), cnt(0), tbl[i].cnt);
            chk($sformatf("t%0d_tick", i + 1), tick[0], tbl[i].tk);
            chk($sformatf("t%0d_out", i + 1), out[0], tbl[i].o);
        end
        bad = 0;
        for (int k = 13; k <= 18; k++) begin
            step();
            if (tick[0] !== (k == 18)) bad++;
        end
        chk("p0_tick13_18", bad, 0);
        chk("idle_ch4_count", cnt(4), 0);

        // one-shot ch1 top=3
        wr_cfg(1, 3, 3, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("os_tick_e%0d", k), tick[1], (k == 4));
            chk($sformatf("os_run_e%0d", k), running[1], (k < 4));
        end
        bad = 0;
        nt  = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tick[1]) nt++;
            if (cnt(1) !== 8'd0 || running[1] !== 1'b0) bad++;
        end
        chk("os_no_more_ticks", nt, 0);
        chk("os_quiet", bad, 0);

        // enable freeze on ch0 top=7
        wr_cfg(0, 7, 7, 1'b0);
        step();
        step();
        step();
        chk("en_cnt3", cnt(0), 3);
        en[0] = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (cnt(0) !== 8'd3 || tick[0] !== 1'b0) bad++;
        end
        chk("en_hold", bad, 0);
        en[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("en_resume_tick%0d", k), tick[0], (k == 5));
        end

        // write ch2 on its wrap cycle
        wr_cfg(2, 4, 4, 1'b0);
        for (int k = 0; k < 4; k++) step();
        chk("w2_at_top", cnt(2), 4);
        wr_cfg(2, 2, 2, 1'b0);
        chk("w2_no_tick", tick[2], 0);
        chk("w2_count0", cnt(2), 0);
        chk("w2_running", running[2], 1);
        step();
        step();
        chk("w2_cnt2", cnt(2), 2);
        chk("w2_tick_pre", tick[2], 0);
        step();
        chk("w2_new_period_tick", tick[2], 1);

        // top=0 on ch3
        wr_cfg(3, 0, 0, 1'b0);
        chk("w3_first_tick", tick[3], 0);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (tick[3] !== 1'b1 || out[3] !== 1'b0 || cnt(3) !== 8'd0) bad++;
        end
        chk("top0_every_cycle", bad, 0);

        // out-of-range channel writes
        wr_cfg(5, 1, 0, 1'b1);
        wr_cfg(7, 1, 0, 1'b1);
        chk("oor_running", running, 5'b01101);
        chk("oor_ch4_count", cnt(4), 0);
        chk("oor_ch3_tick", tick[3], 1);

        // asynchronous reset mid-count
        #2;
        n_reset = 1'b0;
        #1;
        chk("arst_tick", tick, 0);
        chk("arst_out", out, 0);
        chk("arst_running", running, 0);
        chk("arst_count", count, 0);
        n_reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (running !== 5'b0 || count !== '0 || tick !== 5'b0) bad++;
        end
        chk("post_rst_idle", bad, 0);

`ifdef DIVIDER_IRQ_EN
        chk("irq_rst", irq_pending, 0);
        wr_cfg(0, 2, 2, 1'b0);
        step();
        step();
        chk("irq_before_tick", irq, 0);
        step();
        chk("irq_first_tick", irq, 1);
        chk("irq_pending0", irq_pending, 5'b00001);
        step();
        step();
        irq_ack[0] = 1'b1;
        step();
        chk("irq_ack_on_tick_t", tick[0], 1);
        chk("irq_ack_on_tick", irq_pending[0], 1);
        step();
        chk("irq_ack_clears", irq, 0);
        irq_ack[0] = 1'b0;
        step();
        step();
        chk("irq_again", irq, 1);
        wr_cfg(0, 2, 2, 1'b0);
        chk("irq_write_keeps", irq_pending[0], 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
